// File: rtl/frame_centroid.sv
// Per-frame centroid of orange pixels: accumulates x/y sums and a count while a frame is
// scanned, then divides with two serial restoring dividers. Optional bbox: FRAME_CENTROID_BBOX_EN.
module frame_centroid #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        vsync,
  input  logic        is_orange,
  output logic [9:0]  centroid_x,
  output logic [9:0]  centroid_y,
  output logic [18:0] pixel_count,
  output logic        detected,
  output logic        frame_valid,
  output logic        overrun,
  output logic [9:0]  bbox_xmin,
  output logic [9:0]  bbox_xmax,
  output logic [9:0]  bbox_ymin,
  output logic [9:0]  bbox_ymax
);

  localparam int unsigned CW        = 10;
  localparam int unsigned SW        = 28;
  localparam int unsigned NW        = 19;
  localparam int unsigned STW       = 5;
  localparam int unsigned DIV_STEPS = 28;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVIDE  = 2'd1;
  localparam logic [1:0] S_PUBLISH = 2'd2;

  localparam logic [CW-1:0]  X_MAX     = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0]  Y_MAX     = CW'(V_ACTIVE - 1);
  localparam logic [NW-1:0]  CNT_MAX   = '1;
  localparam logic [NW-1:0]  MIN_CNT   = NW'(MIN_PIXELS);
  localparam logic [STW-1:0] LAST_STEP = STW'(DIV_STEPS - 1);

  logic [1:0]     state_q, state_d;
  logic [STW-1:0] step_q, step_d;
  logic           vsync_q, vsync_prev_q, active_prev_q;
  logic [CW-1:0]  x_q, x_d, y_q, y_d;
  logic [SW-1:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  dvd_x_q, dvd_x_d, dvd_y_q, dvd_y_d, dvd_x_n, dvd_y_n;
  logic [NW-1:0]  rem_x_q, rem_x_d, rem_y_q, rem_y_d, rem_x_n, rem_y_n;
  logic [NW-1:0]  dvs_q, dvs_d, snap_cnt_q, snap_cnt_d;
  logic           snap_det_q, snap_det_d;
  logic [CW-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [NW-1:0]  pc_q, pc_d;
  logic           det_q, det_d, fv_q, fv_d, ovr_q, ovr_d;
  logic           frame_end_c, line_end_c, pix_c, snap_c, pub_c;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [NW+SW-1:0] div_step(input logic [NW-1:0] rem,
                                               input logic [SW-1:0] dvd,
                                               input logic [NW-1:0] dvs);
    logic [NW:0] trial;
    trial = {rem, dvd[SW-1]};
    if (trial >= {1'b0, dvs}) begin
      div_step = {NW'(trial - {1'b0, dvs}), dvd[SW-2:0], 1'b1};
    end else begin
      div_step = {trial[NW-1:0], dvd[SW-2:0], 1'b0};
    end
  endfunction

  assign frame_end_c = vsync_prev_q & ~vsync_q;
  assign line_end_c  = active_prev_q & ~active;
  assign pix_c       = active & is_orange;

  // Control FSM: a frame end during DIVIDE is dropped and flagged as overrun.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    snap_c  = 1'b0;
    pub_c   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_end_c) begin
          snap_c  = 1'b1;
          state_d = S_DIVIDE;
          step_d  = '0;
        end
      end
      S_DIVIDE: begin
        step_d = step_q + STW'(1);
        ovr_d  = frame_end_c;
        if (step_q == LAST_STEP) begin
          pub_c   = 1'b1;
          state_d = S_PUBLISH;
        end
      end
      S_PUBLISH: begin
        state_d = S_IDLE;
        if (frame_end_c) begin
          snap_c  = 1'b1;
          state_d = S_DIVIDE;
          step_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fv_d = pub_c;
  end

  assign {rem_x_n, dvd_x_n} = div_step(rem_x_q, dvd_x_q, dvs_q);
  assign {rem_y_n, dvd_y_n} = div_step(rem_y_q, dvd_y_q, dvs_q);

  // Scan counters, accumulators, divider operands and published results.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    sum_x_d    = sum_x_q;
    sum_y_d    = sum_y_q;
    cnt_d      = cnt_q;
    dvd_x_d    = dvd_x_q;
    dvd_y_d    = dvd_y_q;
    rem_x_d    = rem_x_q;
    rem_y_d    = rem_y_q;
    dvs_d      = dvs_q;
    snap_cnt_d = snap_cnt_q;
    snap_det_d = snap_det_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    pc_d       = pc_q;
    det_d      = det_q;

    if (active && (x_q != X_MAX)) x_d = x_q + CW'(1);
    if (line_end_c) begin
      x_d = '0;
      if (y_q != Y_MAX) y_d = y_q + CW'(1);
    end
    if (pix_c) begin
      sum_x_d = sum_x_q + SW'(x_q);
      sum_y_d = sum_y_q + SW'(y_q);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + NW'(1);
    end

    if (state_q == S_DIVIDE) begin
      dvd_x_d = dvd_x_n;
      dvd_y_d = dvd_y_n;
      rem_x_d = rem_x_n;
      rem_y_d = rem_y_n;
    end

    // An empty frame divides by 1 so the datapath never sees a zero divisor.
    if (snap_c) begin
      dvd_x_d    = sum_x_q;
      dvd_y_d    = sum_y_q;
      rem_x_d    = '0;
      rem_y_d    = '0;
      dvs_d      = (cnt_q == '0) ? NW'(1) : cnt_q;
      snap_cnt_d = cnt_q;
      snap_det_d = (cnt_q >= MIN_CNT);
    end

    if (pub_c) begin
      pc_d  = snap_cnt_q;
      det_d = snap_det_q;
      cx_d  = snap_det_q ? dvd_x_n[CW-1:0] : '0;
      cy_d  = snap_det_q ? dvd_y_n[CW-1:0] : '0;
    end

    if (frame_end_c) begin
      x_d     = '0;
      y_d     = '0;
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      vsync_q       <= 1'b0;
      vsync_prev_q  <= 1'b0;
      active_prev_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      sum_x_q       <= '0;
      sum_y_q       <= '0;
      cnt_q         <= '0;
      dvd_x_q       <= '0;
      dvd_y_q       <= '0;
      rem_x_q       <= '0;
      rem_y_q       <= '0;
      dvs_q         <= '0;
      snap_cnt_q    <= '0;
      snap_det_q    <= 1'b0;
      cx_q          <= '0;
      cy_q          <= '0;
      pc_q          <= '0;
      det_q         <= 1'b0;
      fv_q          <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      vsync_q       <= vsync;
      vsync_prev_q  <= vsync_q;
      active_prev_q <= active;
      x_q           <= x_d;
      y_q           <= y_d;
      sum_x_q       <= sum_x_d;
      sum_y_q       <= sum_y_d;
      cnt_q         <= cnt_d;
      dvd_x_q       <= dvd_x_d;
      dvd_y_q       <= dvd_y_d;
      rem_x_q       <= rem_x_d;
      rem_y_q       <= rem_y_d;
      dvs_q         <= dvs_d;
      snap_cnt_q    <= snap_cnt_d;
      snap_det_q    <= snap_det_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      pc_q          <= pc_d;
      det_q         <= det_d;
      fv_q          <= fv_d;
      ovr_q         <= ovr_d;
    end
  end

  assign centroid_x  = cx_q;
  assign centroid_y  = cy_q;
  assign pixel_count = pc_q;
  assign detected    = det_q;
  assign frame_valid = fv_q;
  assign overrun     = ovr_q;

`ifdef FRAME_CENTROID_BBOX_EN
  logic [CW-1:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;
  logic [CW-1:0] sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
  logic [CW-1:0] ox0_q, ox0_d, ox1_q, ox1_d, oy0_q, oy0_d, oy1_q, oy1_d;

  // The first orange pixel of a frame (count still zero) seeds all four extents.
  always_comb begin
    bx0_d = bx0_q;  bx1_d = bx1_q;  by0_d = by0_q;  by1_d = by1_q;
    sx0_d = sx0_q;  sx1_d = sx1_q;  sy0_d = sy0_q;  sy1_d = sy1_q;
    ox0_d = ox0_q;  ox1_d = ox1_q;  oy0_d = oy0_q;  oy1_d = oy1_q;
    if (pix_c) begin
      if (cnt_q == '0) begin
        bx0_d = x_q;  bx1_d = x_q;  by0_d = y_q;  by1_d = y_q;
      end else begin
        if (x_q < bx0_q) bx0_d = x_q;
        if (x_q > bx1_q) bx1_d = x_q;
        if (y_q < by0_q) by0_d = y_q;
        if (y_q > by1_q) by1_d = y_q;
      end
    end
    if (snap_c) begin
      sx0_d = bx0_q;  sx1_d = bx1_q;  sy0_d = by0_q;  sy1_d = by1_q;
    end
    if (pub_c) begin
      ox0_d = snap_det_q ? sx0_q : '0;
      ox1_d = snap_det_q ? sx1_q : '0;
      oy0_d = snap_det_q ? sy0_q : '0;
      oy1_d = snap_det_q ? sy1_q : '0;
    end
    if (frame_end_c) begin
      bx0_d = '0;  bx1_d = '0;  by0_d = '0;  by1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx0_q <= '0;  bx1_q <= '0;  by0_q <= '0;  by1_q <= '0;
      sx0_q <= '0;  sx1_q <= '0;  sy0_q <= '0;  sy1_q <= '0;
      ox0_q <= '0;  ox1_q <= '0;  oy0_q <= '0;  oy1_q <= '0;
    end else begin
      bx0_q <= bx0_d;  bx1_q <= bx1_d;  by0_q <= by0_d;  by1_q <= by1_d;
      sx0_q <= sx0_d;  sx1_q <= sx1_d;  sy0_q <= sy0_d;  sy1_q <= sy1_d;
      ox0_q <= ox0_d;  ox1_q <= ox1_d;  oy0_q <= oy0_d;  oy1_q <= oy1_d;
    end
  end

  assign bbox_xmin = ox0_q;
  assign bbox_xmax = ox1_q;
  assign bbox_ymin = oy0_q;
  assign bbox_ymax = oy1_q;
`else
  assign bbox_xmin = '0;
  assign bbox_xmax = '0;
  assign bbox_ymin = '0;
  assign bbox_ymax = '0;
`endif

endmodule

// File: tb/tb_frame_centroid.sv
// Directed bench for frame_centroid: two instances (MIN_PIXELS 8 and 64) share one pixel stream.
module tb_frame_centroid;

  logic clk = 1'b0;
  logic rst_n, active, vsync, is_orange;

  logic [9:0]  cx [2];
  logic [9:0]  cy [2];
  logic [18:0] pc [2];
  logic        det [2];
  logic        fv [2];
  logic        ovr [2];
  logic [9:0]  bx0 [2];
  logic [9:0]  bx1 [2];
  logic [9:0]  by0 [2];
  logic [9:0]  by1 [2];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int fv_n [2] = '{0, 0};
  int fv_cyc [2] = '{0, 0};
  int ovr_n [2] = '{0, 0};

  always #5 clk = ~clk;

  frame_centroid #(.MIN_PIXELS(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .active(active), .vsync(vsync), .is_orange(is_orange),
    .centroid_x(cx[0]), .centroid_y(cy[0]), .pixel_count(pc[0]), .detected(det[0]),
    .frame_valid(fv[0]), .overrun(ovr[0]),
    .bbox_xmin(bx0[0]), .bbox_xmax(bx1[0]), .bbox_ymin(by0[0]), .bbox_ymax(by1[0])
  );

  frame_centroid #(.MIN_PIXELS(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .active(active), .vsync(vsync), .is_orange(is_orange),
    .centroid_x(cx[1]), .centroid_y(cy[1]), .pixel_count(pc[1]), .detected(det[1]),
    .frame_valid(fv[1]), .overrun(ovr[1]),
    .bbox_xmin(bx0[1]), .bbox_xmax(bx1[1]), .bbox_ymin(by0[1]), .bbox_ymax(by1[1])
  );

  // Pulse monitor: counts frame_valid / overrun pulses and remembers when frame_valid fired.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (fv[d] === 1'b1) begin
        fv_n[d]   = fv_n[d] + 1;
        fv_cyc[d] = cyc;
      end
      if (ovr[d] === 1'b1) ovr_n[d] = ovr_n[d] + 1;
    end
  end

  task automatic line(input int len, input int ox0, input int ox1);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      active    = 1'b1;
      is_orange = (i >= ox0) && (i <= ox1);
    end
    repeat (2) begin
      @(negedge clk);
      active    = 1'b0;
      is_orange = 1'b0;
    end
  endtask

  task automatic block_frame;
    for (int r = 0; r < 54; r++) begin
      if (r >= 50) line(104, 100, 103);
      else line(1, 1, 0);
    end
  endtask

  task automatic frame_end(output int c0);
    @(negedge clk);
    active    = 1'b0;
    is_orange = 1'b0;
    vsync     = 1'b0;
    c0        = cyc;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic wait_publish(input int c0);
    while (cyc < c0 + 34) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; active = 1'b0; vsync = 1'b1; is_orange = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d], fv[d], ovr[d], bx0[d], bx1[d], by0[d], by1[d]} !== '0) begin
        nerr++;
        $display("FAIL reset dut%0d: cx=%0d cy=%0d pc=%0d det=%0b fv=%0b ovr=%0b, want all 0",
                 d, cx[d], cy[d], pc[d], det[d], fv[d], ovr[d]);
      end
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_block;
    int c0, n0;
    logic [39:0] exp [2];
    logic [39:0] bexp;
    n0 = fv_n[0];
    block_frame();
    frame_end(c0);
    wait_publish(c0);
    nvec++;
    if (fv_n[0] != n0 + 1 || fv_cyc[0] != c0 + 30) begin
      nerr++;
      $display("FAIL block_latency: pulses=%0d at cycle %0d, want 1 at cycle %0d",
               fv_n[0] - n0, fv_cyc[0], c0 + 30);
    end
    exp[0] = {10'd101, 10'd51, 19'd16, 1'b1};
    exp[1] = {10'd0, 10'd0, 19'd16, 1'b0};
`ifdef FRAME_CENTROID_BBOX_EN
    bexp = {10'd100, 10'd103, 10'd50, 10'd53};
`else
    bexp = '0;
`endif
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d]} !== exp[d]) begin
        nerr++;
        $display("FAIL block dut%0d: got cx=%0d cy=%0d pc=%0d det=%0b, want %h",
                 d, cx[d], cy[d], pc[d], det[d], exp[d]);
      end
      nvec++;
      if ({bx0[d], bx1[d], by0[d], by1[d]} !== ((d == 0) ? bexp : 40'd0)) begin
        nerr++;
        $display("FAIL block_bbox dut%0d: got %0d %0d %0d %0d", d, bx0[d], bx1[d], by0[d], by1[d]);
      end
    end
  endtask

  task automatic test_empty;
    int c0, n0;
    n0 = fv_n[1];
    frame_end(c0);
    wait_publish(c0);
    nvec++;
    if (fv_n[1] != n0 + 1 || fv_cyc[1] != c0 + 30) begin
      nerr++;
      $display("FAIL empty_latency: pulses=%0d at cycle %0d, want 1 at cycle %0d",
               fv_n[1] - n0, fv_cyc[1], c0 + 30);
    end
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d], bx0[d], bx1[d], by0[d], by1[d]} !== '0) begin
        nerr++;
        $display("FAIL empty dut%0d: got cx=%0d cy=%0d pc=%0d det=%0b, want all 0",
                 d, cx[d], cy[d], pc[d], det[d]);
      end
    end
  endtask

  task automatic test_threshold;
    int c0;
    logic [39:0] exp [2];
    line(63, 0, 62);
    frame_end(c0);
    wait_publish(c0);
    exp[0] = {10'd31, 10'd0, 19'd63, 1'b1};
    exp[1] = {10'd0, 10'd0, 19'd63, 1'b0};
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d]} !== exp[d]) begin
        nerr++;
        $display("FAIL thresh63 dut%0d: got cx=%0d cy=%0d pc=%0d det=%0b, want %h",
                 d, cx[d], cy[d], pc[d], det[d], exp[d]);
      end
    end
    line(64, 0, 63);
    frame_end(c0);
    wait_publish(c0);
    exp[0] = {10'd31, 10'd0, 19'd64, 1'b1};
    exp[1] = {10'd31, 10'd0, 19'd64, 1'b1};
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d]} !== exp[d]) begin
        nerr++;
        $display("FAIL thresh64 dut%0d: got cx=%0d cy=%0d pc=%0d det=%0b, want %h",
                 d, cx[d], cy[d], pc[d], det[d], exp[d]);
      end
    end
  endtask

  task automatic test_hold;
    int c0, n0;
    logic [39:0] exp [2];
    n0 = fv_n[0];
    line(10, 0, 9);
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d]} !== {10'd31, 10'd0, 19'd64, 1'b1} || fv_n[0] != n0) begin
        nerr++;
        $display("FAIL hold dut%0d: got cx=%0d cy=%0d pc=%0d det=%0b pulses=%0d, want 31 0 64 1 pulses=0",
                 d, cx[d], cy[d], pc[d], det[d], fv_n[0] - n0);
      end
    end
    frame_end(c0);
    wait_publish(c0);
    exp[0] = {10'd4, 10'd0, 19'd10, 1'b1};
    exp[1] = {10'd0, 10'd0, 19'd10, 1'b0};
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({cx[d], cy[d], pc[d], det[d]} !== exp[d]) begin
        nerr++;
        $display("FAIL hold_next dut%0d: got cx=%0d cy=%0d pc=%0d det=%0b, want %h",
                 d, cx[d], cy[d], pc[d], det[d], exp[d]);
      end
    end
  endtask

  task automatic test_overrun;
    int c0, c1, n0, o0;
    n0 = fv_n[0];
    o0 = ovr_n[0];
    block_frame();
    frame_end(c0);
    line(5, 0, 4);
    while (cyc < c0 + 10) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    wait_publish(c0);
    nvec++;
    if (ovr_n[0] != o0 + 1 || ovr_n[1] != o0 + 1) begin
      nerr++;
      $display("FAIL overrun_pulse: got %0d/%0d pulses, want 1", ovr_n[0] - o0, ovr_n[1] - o0);
    end
    nvec++;
    if (fv_n[0] != n0 + 1 || fv_cyc[0] != c0 + 30) begin
      nerr++;
      $display("FAIL overrun_latency: pulses=%0d at cycle %0d, want 1 at cycle %0d",
               fv_n[0] - n0, fv_cyc[0], c0 + 30);
    end
    nvec++;
    if ({cx[0], cy[0], pc[0], det[0]} !== {10'd101, 10'd51, 19'd16, 1'b1}) begin
      nerr++;
      $display("FAIL overrun_first: got cx=%0d cy=%0d pc=%0d det=%0b, want 101 51 16 1",
               cx[0], cy[0], pc[0], det[0]);
    end
    frame_end(c1);
    wait_publish(c1);
    nvec++;
    if ({cx[0], cy[0], pc[0], det[0]} !== '0 || fv_n[0] != n0 + 2) begin
      nerr++;
      $display("FAIL overrun_discard: got cx=%0d cy=%0d pc=%0d det=%0b, want 0 0 0 0",
               cx[0], cy[0], pc[0], det[0]);
    end
  endtask

  task automatic test_reset_mid;
    int c0, n0;
    block_frame();
    frame_end(c0);
    wait_publish(c0);
    n0 = fv_n[0];
    block_frame();
    frame_end(c0);
    while (cyc < c0 + 16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({cx[0], cy[0], pc[0], det[0], fv[0]} !== '0) begin
      nerr++;
      $display("FAIL reset_mid_now: got cx=%0d cy=%0d pc=%0d det=%0b, want all 0",
               cx[0], cy[0], pc[0], det[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (cyc < c0 + 45) @(negedge clk);
    nvec++;
    if (fv_n[0] != n0 || {cx[0], cy[0], pc[0], det[0], bx0[0], bx1[0], by0[0], by1[0]} !== '0) begin
      nerr++;
      $display("FAIL reset_mid_quiet: pulses=%0d cx=%0d pc=%0d, want 0 pulses and zero outputs",
               fv_n[0] - n0, cx[0], pc[0]);
    end
    block_frame();
    frame_end(c0);
    wait_publish(c0);
    nvec++;
    if ({cx[0], cy[0], pc[0], det[0]} !== {10'd101, 10'd51, 19'd16, 1'b1} || fv_cyc[0] != c0 + 30) begin
      nerr++;
      $display("FAIL reset_mid_after: got cx=%0d cy=%0d pc=%0d det=%0b at %0d, want 101 51 16 1 at %0d",
               cx[0], cy[0], pc[0], det[0], fv_cyc[0], c0 + 30);
    end
  endtask

  initial begin
    test_reset();
    test_block();
    test_empty();
    test_threshold();
    test_hold();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/frame_centroid.md
FRAME_CENTROID -- requirements
Module: frame_centroid

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter MIN_PIXELS, default 64, minimum orange pixel count for a detection.
REQ-004 SHALL have port clk  input  1  pixel clock, shared with the VGA timing domain.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port active  input  1  high while the current pixel is in the visible area.
REQ-007 SHALL have port vsync  input  1  active-low vertical sync from the VGA timing block.
REQ-008 SHALL have port is_orange  input  1  per-pixel orange classification, aligned with active.
REQ-009 SHALL have port centroid_x  output  10  mean x of orange pixels in the last frame.
REQ-010 SHALL have port centroid_y  output  10  mean y of orange pixels in the last frame.
REQ-011 SHALL have port pixel_count  output  19  orange pixel count of the last frame.
REQ-012 SHALL have port detected  output  1  high when pixel_count >= MIN_PIXELS.
REQ-013 SHALL have port frame_valid  output  1  one-cycle pulse when outputs update.
REQ-014 SHALL have port overrun  output  1  one-cycle pulse when a frame end is dropped.
REQ-015 SHALL have ports bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  output  10 each  bounding box of orange pixels.

Function
REQ-016 SHALL keep x counter: +1 per cycle with active high, cleared on active falling edge, saturating at H_ACTIVE-1.
REQ-017 SHALL keep y counter: +1 on each active falling edge, cleared at frame end, saturating at V_ACTIVE-1.
REQ-018 SHALL, per cycle with active and is_orange high, add x to sum_x (28 bits), y to sum_y (28 bits) and 1 to count (19 bits, saturating).
REQ-019 SHALL ignore is_orange while active is low.
REQ-020 SHALL detect frame end on cycle E, where registered vsync is 0 and its previous sample was 1.
REQ-021 SHALL, at E, snapshot sums and count into divider operands and clear accumulators and counters in the same cycle.
REQ-022 SHALL implement states IDLE, DIVIDE and PUBLISH: IDLE->DIVIDE at E; DIVIDE for exactly 28 cycles (E+1..E+28); PUBLISH at E+29; then IDLE.
REQ-023 SHALL compute sum_x/count and sum_y/count by two parallel restoring dividers, one quotient bit per cycle, truncated (floor), with the low 10 bits output.
REQ-024 SHALL, in PUBLISH, update all outputs and assert frame_valid for exactly one cycle (fixed 29-cycle latency from E).
REQ-025 SHALL, when snapshot count < MIN_PIXELS (including 0), publish centroid_x = centroid_y = 0 and detected = 0, with no divide-by-zero side effects, and keep the same latency.
REQ-026 SHALL hold all outputs stable between PUBLISH cycles.
REQ-027 SHALL keep accumulating pixels during DIVIDE and PUBLISH.
REQ-028 SHALL, on a frame end while in DIVIDE, discard that frame's data (clear the accumulators), pulse overrun for one cycle, and continue the current division undisturbed.

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE and set all counters, accumulators and outputs to 0.
REQ-030 SHALL treat reset mid-DIVIDE as abandoning the division, with no frame_valid pulse.
REQ-031 SHALL treat the first vsync falling edge after reset release as a normal frame end.

Configuration
REQ-032 SHALL, with FRAME_CENTROID_BBOX_EN defined, track min/max x and y of orange pixels per frame and publish them in PUBLISH, with zeros when detected = 0.
REQ-033 SHALL, without FRAME_CENTROID_BBOX_EN, keep the bbox ports present, tie them to 0 and include no bbox logic.

Verification
REQ-034 SHALL cover: MIN_PIXELS=8, 4x4 orange block at x 100..103, y 50..53 -> frame_valid 29 cycles after E, centroid_x=101, centroid_y=51, pixel_count=16, detected=1.
REQ-035 SHALL cover: frame with no orange pixels -> pixel_count=0, centroid 0/0, detected=0, frame_valid still at E+29.
REQ-036 SHALL cover: MIN_PIXELS=64, 63 orange pixels -> detected=0, centroid 0; next frame with 64 pixels -> detected=1.
REQ-037 SHALL cover: second vsync falling edge 10 cycles after the first -> overrun pulse, first frame published correctly, second frame data discarded.
REQ-038 SHALL cover: rst_n low at E+15 -> no frame_valid, all outputs 0, next frame processed normally.
REQ-039 SHALL cover: FRAME_CENTROID_BBOX_EN defined with the block from REQ-034 -> bbox_xmin=100, bbox_xmax=103, bbox_ymin=50, bbox_ymax=53.
